// File: rtl/plic_claim_agent_if.sv
// PLIC MMIO port plus consumer handshake for plic_claim_agent.
// master: the claim agent. slave: the arbiter/PLIC side and the consumer.
interface plic_claim_agent_if #(
    parameter int W_INT_ID = 6
);
    logic                o_req;
    logic                i_gnt;
    logic [29:0]         w_offset;
    logic                w_we;
    logic [31:0]         w_wdata;
    logic                w_re;
    logic [31:0]         w_rdata;
    logic                o_irq_valid;
    logic [W_INT_ID-1:0] o_irq_id;
    logic                i_irq_ready;
    logic                i_irq_done;

    modport master (
        output o_req, w_offset, w_we, w_wdata, w_re, o_irq_valid, o_irq_id,
        input  i_gnt, w_rdata, i_irq_ready, i_irq_done
    );

    modport slave (
        input  o_req, w_offset, w_we, w_wdata, w_re, o_irq_valid, o_irq_id,
        output i_gnt, w_rdata, i_irq_ready, i_irq_done
    );
endinterface

// File: rtl/plic_claim_agent.sv
// Hart-side claim agent for one PLIC context: programs the threshold after
// reset, claims pending interrupts over the shared MMIO port, hands the ID
// to a hardware consumer and writes the completion once it reports done.
// Optional claim/spurious counters are built when PLIC_AGENT_STATS_EN is defined.
module plic_claim_agent #(
    parameter int CTX       = 0,
    parameter int W_INT_ID  = 6,
    parameter int THRS_INIT = 0,
    parameter int HOLDOFF   = 2
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    input  logic                      w_eip,
    plic_claim_agent_if.master        bus,
    output logic                      o_busy,
    output logic [31:0]               o_claim_cnt,
    output logic [31:0]               o_spur_cnt
);

    localparam logic [29:0] THRS_OFF  = 30'(32'h0020_0000 + 32'h0000_1000 * CTX);
    localparam logic [29:0] CLAIM_OFF = 30'(32'h0020_0004 + 32'h0000_1000 * CTX);
    localparam int          HW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CLAIM,
        S_RDWAIT,
        S_DISPATCH,
        S_SERVICE,
        S_COMPLETE
    } state_t;

    state_t              state;
    logic [W_INT_ID-1:0] id_q;
    logic [HW-1:0]       hold_q;
    logic                req_q;
    logic                valid_q;
    logic                busy_q;
    logic                issue;
    logic [W_INT_ID-1:0] rd_id;
    logic                rdata_unused;

    assign issue        = req_q && bus.i_gnt;
    assign rd_id        = bus.w_rdata[W_INT_ID-1:0];
    assign rdata_unused = ^bus.w_rdata[31:W_INT_ID];

    // Sequencer: threshold init, claim, dispatch, service wait, complete, holdoff.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state   <= S_INIT;
            id_q    <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (issue) begin
                        state  <= S_IDLE;
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        req_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HW'(1);
                    end else if (w_eip) begin
                        state  <= S_CLAIM;
                        req_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_CLAIM: begin
                    if (issue) begin
                        state <= S_RDWAIT;
                        req_q <= 1'b0;
                    end
                end
                S_RDWAIT: begin
                    id_q <= rd_id;
                    if (rd_id == '0) begin
                        state  <= S_IDLE;
                        hold_q <= HOLD_LOAD;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= S_DISPATCH;
                        valid_q <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (bus.i_irq_ready) begin
                        valid_q <= 1'b0;
                        if (bus.i_irq_done) begin
                            state <= S_COMPLETE;
                            req_q <= 1'b1;
                        end else begin
                            state <= S_SERVICE;
                        end
                    end
                end
                S_SERVICE: begin
                    if (bus.i_irq_done) begin
                        state <= S_COMPLETE;
                        req_q <= 1'b1;
                    end
                end
                S_COMPLETE: begin
                    if (issue) begin
                        state  <= S_IDLE;
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                        hold_q <= HOLD_LOAD;
                    end
                end
                default: begin
                    state   <= S_INIT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bus strobes, offset and data exist only in the granted issue cycle.
    always_comb begin
        bus.w_we     = 1'b0;
        bus.w_re     = 1'b0;
        bus.w_offset = '0;
        bus.w_wdata  = '0;
        if (issue) begin
            case (state)
                S_INIT: begin
                    bus.w_we     = 1'b1;
                    bus.w_offset = THRS_OFF;
                    bus.w_wdata  = 32'(THRS_INIT);
                end
                S_CLAIM: begin
                    bus.w_re     = 1'b1;
                    bus.w_offset = CLAIM_OFF;
                end
                S_COMPLETE: begin
                    bus.w_we     = 1'b1;
                    bus.w_offset = CLAIM_OFF;
                    bus.w_wdata  = 32'(id_q);
                end
                default: begin
                    bus.w_we = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req       = req_q;
    assign bus.o_irq_valid = valid_q;
    assign bus.o_irq_id    = id_q;
    assign o_busy          = busy_q;

`ifdef PLIC_AGENT_STATS_EN
    logic [31:0] claim_cnt_q;
    logic [31:0] spur_cnt_q;

    // Saturating tallies of real and spurious claims, counted as the read returns.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            claim_cnt_q <= '0;
            spur_cnt_q  <= '0;
        end else if (state == S_RDWAIT) begin
            if (rd_id == '0) begin
                if (spur_cnt_q != 32'hFFFF_FFFF) spur_cnt_q <= spur_cnt_q + 32'd1;
            end else begin
                if (claim_cnt_q != 32'hFFFF_FFFF) claim_cnt_q <= claim_cnt_q + 32'd1;
            end
        end
    end

    assign o_claim_cnt = claim_cnt_q;
    assign o_spur_cnt  = spur_cnt_q;
`else
    assign o_claim_cnt = '0;
    assign o_spur_cnt  = '0;
`endif

endmodule
